race_sequencer: RTL and testbench

RACE_SEQUENCER -- requirements
Module: race_sequencer

---
 rtl/race_sequencer.sv | 138 +++++++++++++
 tb/tb_race_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// Race flow sequencer: idle/setting/countdown/racing/pause/finish,
// physics tick strobe, lap counting, winner decision and race timer.
// Ports: clk, rst (sync, active-high); start, pause_btn, lap_p1, lap_p2
// pulses in; state, count_val, tick, laps_p1/p2, winner, race_time out.
// Optional feature macro: RACE_TIMER_EN (race_time tick counter).
module race_sequencer #(
  parameter int SEC_CYCLES = 25000000,
  parameter int TICK_DIV   = 416667,
  parameter int LAPS       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause_btn,
  input  logic        lap_p1,
  input  logic        lap_p2,
  output logic [2:0]  state,
  output logic [1:0]  count_val,
  output logic        tick,
  output logic [2:0]  laps_p1,
  output logic [2:0]  laps_p2,
  output logic [1:0]  winner,
  output logic [15:0] race_time
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } st_t;

  localparam int SW = (SEC_CYCLES > 2) ? $clog2(SEC_CYCLES) : 1;
  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [2:0]    LAP_LAST = 3'(LAPS - 1);
  localparam logic [2:0]    LAP_MAX  = 3'(LAPS);

  st_t           st;
  logic [SW-1:0] sec_cnt;
  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          win1;
  logic          win2;

  assign state    = st;
  assign div_wrap = (div_cnt == DIV_LAST);
  assign win1     = lap_p1 && (laps_p1 == LAP_LAST);
  assign win2     = lap_p2 && (laps_p2 == LAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      count_val <= 2'd0;
      tick      <= 1'b0;
      laps_p1   <= 3'd0;
      laps_p2   <= 3'd0;
      winner    <= 2'd0;
      sec_cnt   <= '0;
      div_cnt   <= '0;
    end else begin
      tick <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) st <= SETTING;
        end
        SETTING: begin
          if (start) begin
            st        <= COUNTDOWN;
            count_val <= 2'd3;
            sec_cnt   <= '0;
          end
        end
        COUNTDOWN: begin
          if (sec_cnt == SEC_LAST) begin
            sec_cnt   <= '0;
            count_val <= count_val - 2'd1;
            if (count_val == 2'd1) st <= RACING;
          end else begin
            sec_cnt <= sec_cnt + SW'(1);
          end
        end
        RACING: begin
          if (div_wrap) begin
            div_cnt <= '0;
            tick    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
          if (lap_p1 && laps_p1 != LAP_MAX) laps_p1 <= laps_p1 + 3'd1;
          if (lap_p2 && laps_p2 != LAP_MAX) laps_p2 <= laps_p2 + 3'd1;
          // A deciding lap beats a same-cycle pause request.
          if (win1 || win2) begin
            st     <= FINISH;
            winner <= {win2, win1};
          end else if (pause_btn) begin
            st <= PAUSE;
          end
        end
        PAUSE: begin
          // div_cnt is held so the tick phase survives the pause.
          if (pause_btn) st <= RACING;
        end
        FINISH: begin
          if (start) begin
            st      <= IDLE;
            laps_p1 <= 3'd0;
            laps_p2 <= 3'd0;
            winner  <= 2'd0;
            sec_cnt <= '0;
            div_cnt <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef RACE_TIMER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      race_time <= 16'd0;
    end else if (st == FINISH && start) begin
      race_time <= 16'd0;
    end else if (st == RACING && div_wrap &&
                 race_time != 16'hFFFF) begin
      race_time <= race_time + 16'd1;
    end
  end
`else
  assign race_time = 16'd0;
`endif

endmodule

// File: tb/tb_race_sequencer.sv
// Self-checking bench for race_sequencer (SEC_CYCLES=4, TICK_DIV=2,
// LAPS=2) with a state-transition scoreboard queue.
module tb_race_sequencer;

`ifdef RACE_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause_btn;
  logic        lap_p1;
  logic        lap_p2;
  logic [2:0]  state;
  logic [1:0]  count_val;
  logic        tick;
  logic [2:0]  laps_p1;
  logic [2:0]  laps_p2;
  logic [1:0]  winner;
  logic [15:0] race_time;

  int total = 0;
  int bad   = 0;
  int ticks = 0;

  logic [2:0] exp_q[$];
  logic [2:0] prev;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  race_sequencer #(
    .SEC_CYCLES(4),
    .TICK_DIV  (2),
    .LAPS      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause_btn(pause_btn),
    .lap_p1   (lap_p1),
    .lap_p2   (lap_p2),
    .state    (state),
    .count_val(count_val),
    .tick     (tick),
    .laps_p1  (laps_p1),
    .laps_p2  (laps_p2),
    .winner   (winner),
    .race_time(race_time)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick) ticks++;
  endtask

  task automatic pulse(input bit s, input bit p,
                       input bit l1, input bit l2);
    start     = s;
    pause_btn = p;
    lap_p1    = l1;
    lap_p2    = l2;
    step();
    start     = 1'b0;
    pause_btn = 1'b0;
    lap_p1    = 1'b0;
    lap_p2    = 1'b0;
  endtask

  task automatic rt_chk(input string tag, input int n);
    check(tag, race_time, TMR ? n : 0);
  endtask

  // Every observed state change must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && state !== prev) begin
      if (exp_q.size() == 0) check("st_unexp", state, prev);
      else check("st_seq", state, exp_q.pop_front());
      prev = state;
    end
  end

  task automatic to_racing();
    exp_q.push_back(3'd1);
    pulse(1, 0, 0, 0);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    pulse(1, 0, 0, 0);
    repeat (12) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause_btn = 1'b0;
    lap_p1 = 1'b0; lap_p2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_count", count_val, 0);
    check("rst_tick", tick, 0);
    check("rst_laps1", laps_p1, 0);
    check("rst_laps2", laps_p2, 0);
    check("rst_winner", winner, 0);
    rt_chk("rst_rtime", 0);
    prev   = state;
    mon_en = 1'b1;

    pulse(0, 1, 1, 0);
    check("idle_pause", state, 0);
    check("idle_lap", laps_p1, 0);

    exp_q.push_back(3'd1);
    pulse(1, 0, 0, 0);
    check("setting", state, 1);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    pulse(1, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      check("cd_state", state, 3);
      check("cd_count", count_val, 3 - i / 4);
      if (i == 5) begin
        lap_p1 = 1'b1;
        start  = 1'b1;
      end
      step();
      lap_p1 = 1'b0;
      start  = 1'b0;
    end
    check("race_state", state, 4);
    check("race_count", count_val, 0);
    check("cd_lap", laps_p1, 0);

    ticks = 0;
    repeat (10) step();
    check("ticks_run", ticks, 5);
    rt_chk("rtime_run", 5);
    exp_q.push_back(3'd5);
    pulse(0, 1, 0, 0);
    check("pause_state", state, 5);
    rt_chk("rtime_pause", 5);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    repeat (3) step();
    check("pause_ticks", ticks, 5);
    check("pause_laps1", laps_p1, 0);
    check("pause_laps2", laps_p2, 0);
    check("pause_hold", state, 5);
    exp_q.push_back(3'd4);
    pulse(0, 1, 0, 0);
    check("resume_tick0", tick, 0);
    step();
    check("resume_phase", tick, 1);
    rt_chk("rtime_resume", 6);

    pulse(0, 0, 1, 0);
    check("lap1_one", laps_p1, 1);
    check("lap1_nowin", winner, 0);
    pulse(0, 0, 0, 1);
    check("lap2_one", laps_p2, 1);
    exp_q.push_back(3'd6);
    pulse(0, 1, 1, 1);
    check("tie_state", state, 6);
    check("tie_winner", winner, 3);
    check("tie_laps1", laps_p1, 2);
    check("tie_laps2", laps_p2, 2);
    pulse(0, 0, 1, 1);
    pulse(0, 1, 0, 0);
    check("fin_laps1", laps_p1, 2);
    check("fin_laps2", laps_p2, 2);
    check("fin_state", state, 6);
    rt_chk("rtime_fin", 7);

    exp_q.push_back(3'd0);
    pulse(1, 0, 0, 0);
    check("clr_state", state, 0);
    check("clr_laps1", laps_p1, 0);
    check("clr_laps2", laps_p2, 0);
    check("clr_winner", winner, 0);
    rt_chk("clr_rtime", 0);

    to_racing();
    check("r2_state", state, 4);
    exp_q.push_back(3'd5);
    pulse(1, 1, 0, 0);
    check("r2_sp_pause", state, 5);
    exp_q.push_back(3'd4);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    check("r2_lap1", laps_p1, 1);
    exp_q.push_back(3'd6);
    pulse(0, 0, 1, 1);
    check("r2_win", winner, 1);
    check("r2_laps1", laps_p1, 2);
    check("r2_laps2", laps_p2, 1);
    check("r2_state6", state, 6);
    exp_q.push_back(3'd0);
    pulse(1, 0, 0, 0);

    to_racing();
    pulse(0, 0, 0, 1);
    check("r3_laps2", laps_p2, 1);
    repeat (3) step();
    exp_q.push_back(3'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_state", state, 0);
    check("mrst_count", count_val, 0);
    check("mrst_tick", tick, 0);
    check("mrst_laps1", laps_p1, 0);
    check("mrst_laps2", laps_p2, 0);
    check("mrst_winner", winner, 0);
    rt_chk("mrst_rtime", 0);

    step();
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
